binary_to_bcd_seq: RTL

Parametrised, multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits between binary counters or status registers and display/UART formatting logic, with valid/ready handshakes on both sides. Compared with a single-cycle 5-bit combinational converter, it adds:
- arbitrary input width;
- a configurable digit count;
- overflow detection;
- a significant-digit count for leading-zero blanking.

---
 rtl/binary_to_bcd_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/binary_to_bcd_seq.sv
// binary_to_bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// The input side and the output side each use a valid/ready handshake.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   in_valid      in_data is valid
//   in_ready      converter can accept a new value (IDLE only, never during reset)
//   in_data       unsigned binary value, WIDTH bits
//   out_valid     result valid, held until out_ready
//   out_ready     consumer takes the result
//   out_bcd       packed BCD, digit 0 (units) in [3:0]
//   out_ndigits   number of significant digits, 1..DIGITS
//   out_overflow  input was >= 10^DIGITS; out_bcd holds value mod 10^DIGITS
module binary_to_bcd_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [4*DIGITS-1:0]            out_bcd,
  output logic [$clog2(DIGITS+1)-1:0]    out_ndigits,
  output logic                           out_overflow
);

  localparam int unsigned NdW  = $clog2(DIGITS + 1);
  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_bin;
  logic [BcdW-1:0]  r_bcd;
  logic [CntW-1:0]  r_cnt;
  logic             r_ovf;
  logic [BcdW-1:0]  r_out_bcd;
  logic [NdW-1:0]   r_out_nd;
  logic             r_out_ovf;

  logic [BcdW-1:0]  w_adj;
  logic [BcdW-1:0]  w_bcd_next;
  logic [WIDTH-1:0] w_bin_next;
  logic             w_ovf_next;
  logic [NdW-1:0]   w_nd;

  // Add-3 on every digit >= 5; digits are independent, no carry between them.
  always_comb begin
    w_adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end else begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4];
      end
    end
  end

  // Shift {bcd, bin} left by one; the bit leaving the top digit marks overflow.
  always_comb begin
    w_bcd_next = {w_adj[BcdW-2:0], r_bin[WIDTH-1]};
    w_bin_next = r_bin << 1;
    w_ovf_next = r_ovf | w_adj[BcdW-1];
  end

  // Significant digits of the result about to be registered (1 for an all-zero value).
  always_comb begin
    w_nd = NdW'(1);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (w_bcd_next[4*i +: 4] != 4'd0) begin
        w_nd = NdW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_out_bcd <= '0;
      r_out_nd  <= '0;
      r_out_ovf <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_bin   <= in_data;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_state <= StShift;
          end
        end
        StShift: begin
          r_bin <= w_bin_next;
          r_bcd <= w_bcd_next;
          r_ovf <= w_ovf_next;
          r_cnt <= r_cnt + CntW'(1);
          if (r_cnt == LastCnt) begin
            // Result registers change only here, so they are stable throughout DONE
            // and keep their value after the output handshake.
            r_out_bcd <= w_bcd_next;
            r_out_nd  <= w_nd;
            r_out_ovf <= w_ovf_next;
            r_state   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Gated by rst so the block never advertises readiness while being reset.
  assign in_ready     = (r_state == StIdle) && !rst;
  assign out_valid    = (r_state == StDone);
  assign out_bcd      = r_out_bcd;
  assign out_ndigits  = r_out_nd;
  assign out_overflow = r_out_ovf;

endmodule
